fifo_flush_sync_param: RTL

Parametrised single-clock FIFO with synchronous flush. It is the next generation of the team's flush-capable FIFO and adds:
- configurable data width and depth;
- occupancy count output;
- almost-full and almost-empty thresholds;
- sticky overflow and underflow flags;
- optional overwrite-oldest mode.

It sits between a producer and a consumer in one clock domain. Flush discards all queued entries in a single cycle.

---
 rtl/fifo_pkg.sv | 20 ++
 rtl/fifo_mem.sv | 36 +++
 rtl/fifo_flush_sync_param.sv | 112 +++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared constants and sizing helpers for the flush-capable FIFO family.
//   clog2    - constant ceiling log2, usable in parameter and port declarations
//   cnt_w    - width of an occupancy counter able to hold 0..depth
//   MODE_*   - values for the OVERWRITE parameter
package fifo_pkg;

    localparam int MODE_DROP      = 0;
    localparam int MODE_OVERWRITE = 1;

    function automatic int clog2(input int value);
        int r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) r++;
        return r;
    endfunction

    function automatic int cnt_w(input int depth);
        return clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: DATA_W x DEPTH storage with a synchronous write port and a registered read port.
//   clock, reset  - rising-edge clock, async active-low reset (clears only the read register)
//   we/waddr/wdata - write port, stored at the clock edge when we=1
//   re/raddr/rdata - read port, rdata loads mem[raddr] when re=1 and holds otherwise
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage is never reset so it can map onto plain RAM.
    always_ff @(posedge clock) begin
        if (we) mem[waddr] <= wdata;
    end

    // A read and a write to the same address at one edge returns the old word,
    // which is what lets a full FIFO read and write together.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/fifo_flush_sync_param.sv
// fifo_flush_sync_param: single-clock FIFO with one-cycle synchronous flush, occupancy
// count, almost-full/almost-empty thresholds, sticky overflow/underflow and an optional
// overwrite-oldest mode.
//   clock, reset        - rising-edge clock, async active-low reset
//   fifo_wr_valid_i/data - write request and data
//   fifo_rd_valid_i     - read request; data appears one cycle later
//   fifo_flush_i        - empties the FIFO at the next edge, overrides everything but reset
//   fifo_rd_data_o      - registered read data, held between reads
//   fifo_rd_valid_o     - pulses for the cycle in which fifo_rd_data_o was updated
//   fifo_empty_o/full_o/almost_full_o/almost_empty_o/count_o - decodes of occupancy
//   fifo_ovf_o/udf_o    - sticky error flags, cleared by reset or flush
module fifo_flush_sync_param
    import fifo_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 8,
    parameter int AF_LVL    = DEPTH - 2,
    parameter int AE_LVL    = 1,
    parameter int OVERWRITE = MODE_DROP
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      fifo_wr_valid_i,
    input  logic [DATA_W-1:0]         fifo_wr_data_i,
    input  logic                      fifo_rd_valid_i,
    input  logic                      fifo_flush_i,
    output logic [DATA_W-1:0]         fifo_rd_data_o,
    output logic                      fifo_rd_valid_o,
    output logic                      fifo_empty_o,
    output logic                      fifo_full_o,
    output logic                      fifo_almost_full_o,
    output logic                      fifo_almost_empty_o,
    output logic [cnt_w(DEPTH)-1:0]   fifo_count_o,
    output logic                      fifo_ovf_o,
    output logic                      fifo_udf_o
);

    localparam int ADDR_W = clog2(DEPTH);
    localparam int CW     = cnt_w(DEPTH);
    localparam bit OW     = (OVERWRITE == MODE_OVERWRITE);

    logic [ADDR_W-1:0] wptr, rptr;
    logic [CW-1:0]     count;
    logic              rd_valid, ovf, udf;
    logic              empty, full;
    logic              rd_acc, wr_acc, drop_oldest, cnt_inc, cnt_dec;

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

    always_comb begin
        rd_acc      = fifo_rd_valid_i && !empty && !fifo_flush_i;
        wr_acc      = fifo_wr_valid_i && !fifo_flush_i && (!full || rd_acc || OW);
        // Only reachable in overwrite mode: the new word replaces the oldest one.
        drop_oldest = wr_acc && full && !rd_acc;
        cnt_inc     = wr_acc && !rd_acc && !full;
        cnt_dec     = rd_acc && !wr_acc;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            rd_valid <= 1'b0;
            ovf      <= 1'b0;
            udf      <= 1'b0;
        end else if (fifo_flush_i) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            rd_valid <= 1'b0;
            ovf      <= 1'b0;
            udf      <= 1'b0;
        end else begin
            rd_valid <= rd_acc;
            if (wr_acc) wptr <= wptr + ADDR_W'(1);
            if (rd_acc || drop_oldest) rptr <= rptr + ADDR_W'(1);
            if (cnt_inc) count <= count + CW'(1);
            else if (cnt_dec) count <= count - CW'(1);
            // A write while full is an overflow unless a read made room this cycle,
            // even when overwrite mode keeps the new word.
            if (fifo_wr_valid_i && full && !rd_acc) ovf <= 1'b1;
            if (fifo_rd_valid_i && empty) udf <= 1'b1;
        end
    end

    fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clock  (clock),
        .reset  (reset),
        .we     (wr_acc),
        .waddr  (wptr),
        .wdata  (fifo_wr_data_i),
        .re     (rd_acc),
        .raddr  (rptr),
        .rdata  (fifo_rd_data_o)
    );

    assign fifo_rd_valid_o     = rd_valid;
    assign fifo_empty_o        = empty;
    assign fifo_full_o         = full;
    assign fifo_almost_full_o  = (count >= CW'(AF_LVL));
    assign fifo_almost_empty_o = (count <= CW'(AE_LVL));
    assign fifo_count_o        = count;
    assign fifo_ovf_o          = ovf;
    assign fifo_udf_o          = udf;

endmodule
